// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples synchronized rows,
// debounces whole-scan results and emits the debounced hex key with a one-cycle valid strobe.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 50_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] krow,
    output logic [3:0] kcol,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TICK_W  = $clog2(SCAN_TICKS);
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(SCAN_TICKS - 1);
    localparam logic [TICK_W-1:0]  PRE_TICK   = TICK_W'(SCAN_TICKS - 2);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DEBOUNCE_SCANS);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    // Indexed by {row, col}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    typedef enum logic [1:0] {
        S_DRIVE,
        S_SAMPLE,
        S_EVAL
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] code;
    } result_t;

    localparam result_t RESULT_NONE = '{found: 1'b0, code: 4'h0};

    state_t              r_state;
    state_t              w_state_next;
    logic [TICK_W-1:0]   r_tick;
    logic [1:0]          r_col;
    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_sync;
    result_t             r_scan;
    result_t             r_prev;
    result_t             r_stable;
    logic [MATCH_W-1:0]  r_match;
    logic [MATCH_W-1:0]  w_match_next;
    logic [3:0]          r_key_code;
    logic                r_key_valid;
    logic                r_key_held;
    logic                w_sample_en;
    logic                w_eval_en;
    logic                w_row_hit;
    logic [1:0]          w_row_idx;
    logic                w_same;
    logic                w_accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= krow;
            r_row_sync <= r_row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
            r_col  <= 2'd0;
        end else if (r_tick == LAST_TICK) begin
            r_tick <= '0;
            r_col  <= r_col + 2'd1;
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    assign kcol = ~(4'b0001 << r_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_DRIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // EVAL sits on tick 0 of the next scan, so col 0 dwell timing is untouched.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_DRIVE:  w_state_next = (r_tick == PRE_TICK) ? S_SAMPLE : S_DRIVE;
            S_SAMPLE: w_state_next = (r_col == 2'd3) ? S_EVAL : S_DRIVE;
            S_EVAL:   w_state_next = (r_tick == PRE_TICK) ? S_SAMPLE : S_DRIVE;
            default:  w_state_next = S_DRIVE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_sample_en = 1'b0;
        w_eval_en   = 1'b0;
        case (r_state)
            S_SAMPLE: w_sample_en = 1'b1;
            S_EVAL:   w_eval_en   = 1'b1;
            default:  ;
        endcase
    end

    // Lowest-numbered low row wins within the driven column.
    always_comb begin
        w_row_hit = 1'b0;
        w_row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_row_sync[r]) begin
                w_row_hit = 1'b1;
                w_row_idx = 2'(r);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= RESULT_NONE;
        end else if (w_eval_en) begin
            r_scan <= RESULT_NONE;
        end else if (w_sample_en && !r_scan.found && w_row_hit) begin
            r_scan <= '{found: 1'b1, code: KEY_MAP[{w_row_idx, r_col}]};
        end
    end

    always_comb begin
        w_same       = (r_scan == r_prev);
        w_match_next = MATCH_ONE;
        if (w_same) begin
            w_match_next = (r_match == MATCH_FULL) ? MATCH_FULL : r_match + MATCH_ONE;
        end
        w_accept = w_eval_en && (w_match_next == MATCH_FULL) && (r_scan != r_stable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev   <= RESULT_NONE;
            r_match  <= '0;
            r_stable <= RESULT_NONE;
        end else if (w_eval_en) begin
            r_match <= w_match_next;
            if (!w_same) begin
                r_prev <= r_scan;
            end
            if (w_accept) begin
                r_stable <= r_scan;
            end
        end
    end

    // A release only drops key_held; the last code stays visible downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= w_accept && r_scan.found;
            if (w_accept) begin
                r_key_held <= r_scan.found;
                if (r_scan.found) begin
                    r_key_code <= r_scan.code;
                end
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected key codes, a negedge monitor
// pops and compares on every key_valid pulse.
module tb_keypad_scanner;

    localparam int ST   = 16;
    localparam int DS   = 3;
    localparam int SCAN = 4 * ST;
    localparam int LAT  = 4 * SCAN + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  krow;
    logic [3:0]  kcol;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_pulses = 0;
    logic [3:0]  exp_q [$];
    logic [3:0]  exp_code;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS     (ST),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .krow      (krow),
        .kcol      (kcol),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad model: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        krow = 4'hF;
        for (int r = 0; r < 4; r++) begin
            krow[r] = ~|(pressed[r*4 +: 4] & ~kcol);
        end
    end

    function automatic logic [15:0] key(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_code = exp_q.pop_front();
                check("pulse_code", int'(key_code), int'(exp_code));
                check("pulse_held", int'(key_held), 1);
            end
            n_pulses++;
        end
    end

    task automatic press_expect(input string name, input logic [15:0] keys,
                                input logic [3:0] code, output int lat);
        int base;
        bit got;
        base    = n_pulses;
        exp_q.push_back(code);
        pressed = keys;
        got     = 1'b0;
        lat     = 0;
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk);
            lat = i + 1;
            if (n_pulses != base) begin
                got = 1'b1;
                break;
            end
        end
        check(name, int'(got), 1);
        @(negedge clk);
    endtask

    task automatic release_expect(input string name, input logic [3:0] code);
        int base;
        base    = n_pulses;
        pressed = '0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (!key_held) break;
        end
        check({name, "_held"}, int'(key_held), 0);
        check({name, "_code"}, int'(key_code), int'(code));
        repeat (2 * SCAN) @(negedge clk);
        check({name, "_no_pulse"}, n_pulses, base);
    endtask

    task automatic wait_kcol(input logic [3:0] want);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * SCAN; i++) begin
            @(negedge clk);
            if (kcol == want) begin
                seen = 1'b1;
                break;
            end
        end
        check("kcol_reached", int'(seen), 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         base;
        logic [3:0] ec;

        // Reset state, then idle column rotation.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_kcol", int'(kcol), 'hE);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        rst = 1'b0;
        for (int k = 0; k < 2 * SCAN; k++) begin
            ec = ~(4'b0001 << ((k / ST) % 4));
            check("kcol_seq", int'(kcol), int'(ec));
            @(negedge clk);
        end
        check("idle_code", int'(key_code), 0);
        check("idle_held", int'(key_held), 0);

        // Single held key: one pulse only.
        press_expect("press_7", key(2, 0), 4'h7, lat);
        check("press_7_held", int'(key_held), 1);
        base = n_pulses;
        repeat (20 * SCAN) @(negedge clk);
        check("hold_7_no_repeat", n_pulses, base);

        release_expect("release_7", 4'h7);

        // Bouncing D never settles for three scans.
        base = n_pulses;
        for (int i = 0; i < 15; i++) begin
            pressed = (i % 2 == 0) ? key(3, 3) : 16'h0;
            repeat (20) @(negedge clk);
        end
        check("bounce_d_no_pulse", n_pulses, base);
        press_expect("press_d", key(3, 3), 4'hD, lat);

        // Scan-order priority, then direct key-to-key changes.
        press_expect("press_1_and_c", key(0, 0) | key(2, 3), 4'h1, lat);
        press_expect("switch_to_7", key(2, 0), 4'h7, lat);
        press_expect("switch_to_9", key(2, 2), 4'h9, lat);
        check("switch_9_held", int'(key_held), 1);
        release_expect("release_9", 4'h9);

        // Reset partway through a debounce of key 5.
        wait_kcol(4'b0111);
        wait_kcol(4'b1110);
        pressed = key(1, 1);
        repeat (2 * SCAN + 32) @(negedge clk);
        base = n_pulses;
        rst  = 1'b1;
        #1;
        check("midrst_kcol", int'(kcol), 'hE);
        check("midrst_code", int'(key_code), 0);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_held", int'(key_held), 0);
        repeat (3) @(negedge clk);
        check("midrst_no_pulse", n_pulses, base);
        rst = 1'b0;
        press_expect("press_5_after_rst", key(1, 1), 4'h5, lat);
        check("rst_restarts_debounce", int'(lat >= 3 * SCAN), 1);
        release_expect("release_5", 4'h5);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad (Pmod KYPD style) by driving one active-low column at a time and sampling the active-low rows. Rows are synchronized and the per-scan result is debounced across full scans. The block emits a stable hex key code with a one-cycle valid strobe on each new debounced press. It sits directly upstream of the seven-segment display driver, which latches key_code on key_valid.

Parameters:
SCAN_TICKS, 50_000, clock cycles each column is driven (1 ms at 50 MHz); minimum 4
DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a press or release; minimum 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
krow  in  4  keypad rows, active-low (0 = key in the driven column pressed), asynchronous to clk
kcol  out  4  keypad columns, one-hot active-low; column c drives kcol = ~(4'b0001 << c)
key_code  out  4  last debounced key, hex value
key_valid  out  1  one-cycle pulse when key_code is updated by a new debounced press
key_held  out  1  high while a debounced key is pressed

Behaviour:
- Reset (async assert, sync release): kcol=4'b1110 (col 0), key_code=4'h0, key_valid=0, key_held=0; all counters, scan result and stable state cleared (stable = NONE).
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- krow passes through a 2-FF synchronizer before any use.
- Column dwell:
  - tick counter runs 0..SCAN_TICKS-1 per column.
  - Synchronized rows are sampled on tick SCAN_TICKS-1.
  - kcol advances to the next column on the following cycle, wrapping col 3 -> col 0.
- Per-scan result:
  - The first pressed key in scan order (col 0..3, then row 0..3 within a column) wins.
  - Once a key is found, later columns in the same scan are ignored.
  - No low row in any column gives NONE.
- Evaluation, on the cycle after the col 3 sample:
  - If the result equals the previous scan's result, the match counter increments, saturating at DEBOUNCE_SCANS. Otherwise the match counter resets to 1 and the previous result is replaced.
  - When the match counter reaches DEBOUNCE_SCANS and the result differs from the stable state, the stable state is updated.
  - Update to key K: key_code<=K and key_held<=1 on that cycle; key_valid=1 for exactly that cycle.
  - Update to NONE: key_held<=0; key_code holds its last value; no key_valid.
  - Direct change key A -> key B without an intervening debounced NONE: treated as a new press, so key_code<=B with a new pulse.
- A held key produces exactly one key_valid. A result that matches the stable state produces no pulse.
- Latency: the pulse arrives between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 full scans after a stable press, plus 3 cycles (4*SCAN_TICKS cycles per scan).
- Reset mid-operation clears all state immediately, including an in-progress debounce. No pulse is emitted on reset or on its release.
- State machine states:
  - DRIVE: dwell on the current column.
  - SAMPLE: capture rows on the last tick.
  - EVAL: one cycle after col 3. The dwell timing of col 0 is unaffected: EVAL overlaps tick 0 of the next scan.

Test Plan:
Bench runs SCAN_TICKS=16 and DEBOUNCE_SCANS=3 (64 cycles/scan). The keypad model drives krow from kcol: a pressed key (r,c) pulls krow[r] low only while kcol[c]=0; otherwise krow=4'b1111.
1. Reset, no keys -> kcol sequence 1110,1101,1011,0111 with 16 cycles each, repeating; key_valid never asserts; key_code=0; key_held=0.
2. Hold key 7 (r2,c0), so krow=4'b1011 while col 0 is driven -> exactly one key_valid with key_code=4'h7 and key_held=1, within 4*64+3 cycles of press; no further pulse over 20 more scans.
3. Release after test 2 -> key_held falls within 4*64+3 cycles; key_code stays 4'h7; no key_valid.
4. Bounce key D (r3,c3), toggling every 20 cycles for 300 cycles -> no key_valid; then hold steady -> one pulse with key_code=4'hD.
5. Hold 1 (r0,c0) and C (r2,c3) together -> key_code=4'h1 with one pulse. Then switch from 7 to 9 (r2,c2) with no release gap -> second pulse with key_code=4'h9.
6. Assert rst for 3 cycles after 2 matching scans of key 5 -> outputs reset within the cycle; kcol=1110; no pulse. After release, key 5 still held -> full 3-scan debounce restarts, then a pulse with key_code=4'h5.
